// File: rtl/sum_accumulator.sv
// Saturating running-sum/sample-count feeder for the decimal-digit converter.
// Optional feature: define SUM_ACCUMULATOR_MAX_EN to track the largest accepted sample on max_o.
module sum_accumulator #(
    parameter int unsigned DATA_W = 8,
    parameter int unsigned SUM_W  = 16,
    parameter int unsigned CNT_W  = 8
) (
    input  logic              clk_i,
    input  logic              rst_ni,
    input  logic              clear_i,
    input  logic              valid_i,
    input  logic [DATA_W-1:0] data_i,
    output logic              ready_o,
    output logic [SUM_W-1:0]  sum_o,
    output logic [CNT_W-1:0]  n_o,
    output logic              ovf_o,
    output logic              upd_o,
    output logic [DATA_W-1:0] max_o
);

    localparam int unsigned ADD_W  = SUM_W + 1;
    localparam int unsigned PEND_W = CNT_W + 1;
    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_ACC  = 2'd1,
        S_FULL = 2'd2
    } state_t;

    state_t r_state;
    state_t w_state_nxt;

    logic              r_ready;
    logic              r_s1_valid;
    logic [DATA_W-1:0] r_s1_data;
    logic [SUM_W-1:0]  r_sum;
    logic [CNT_W-1:0]  r_n;
    logic              r_ovf;
    logic              r_upd;

    logic              w_accept;
    logic [ADD_W-1:0]  w_add;
    logic              w_sat;
    logic [PEND_W-1:0] w_pend;
    logic              w_last;

    assign w_accept = valid_i & r_ready & ~clear_i;
    assign w_add    = ADD_W'(r_sum) + ADD_W'(r_s1_data);
    assign w_sat    = r_s1_valid & w_add[SUM_W];
    // Samples already counted plus the one in stage 1 plus this accept.
    assign w_pend   = PEND_W'(r_n) + PEND_W'(r_s1_valid) + PEND_W'(1);
    assign w_last   = w_accept & (w_pend >= PEND_W'(CNT_MAX));

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE:  w_state_nxt = clear_i ? S_IDLE : S_ACC;
            S_ACC: begin
                if (clear_i)               w_state_nxt = S_IDLE;
                else if (w_sat || w_last)  w_state_nxt = S_FULL;
            end
            S_FULL:  if (clear_i) w_state_nxt = S_IDLE;
            default: w_state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_state <= S_IDLE;
            r_ready <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_ready <= (w_state_nxt == S_ACC);
        end
    end

    // Stage 1 captures the sample, stage 2 folds it into the saturating sum.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_s1_valid <= 1'b0;
            r_s1_data  <= '0;
            r_sum      <= '0;
            r_n        <= '0;
            r_ovf      <= 1'b0;
            r_upd      <= 1'b0;
        end else if (clear_i) begin
            r_s1_valid <= 1'b0;
            r_sum      <= '0;
            r_n        <= '0;
            r_ovf      <= 1'b0;
            r_upd      <= 1'b1;
        end else begin
            r_s1_valid <= w_accept;
            if (w_accept) r_s1_data <= data_i;
            r_upd <= r_s1_valid;
            if (r_s1_valid) begin
                r_sum <= w_sat ? '1 : w_add[SUM_W-1:0];
                if (w_sat) r_ovf <= 1'b1;
                if (r_n != CNT_MAX) r_n <= r_n + CNT_W'(1);
            end
        end
    end

`ifdef SUM_ACCUMULATOR_MAX_EN
    logic [DATA_W-1:0] r_max;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_max <= '0;
        end else if (clear_i) begin
            r_max <= '0;
        end else if (r_s1_valid && (r_s1_data > r_max)) begin
            r_max <= r_s1_data;
        end
    end

    assign max_o = r_max;
`else
    assign max_o = '0;
`endif

    assign ready_o = r_ready;
    assign sum_o   = r_sum;
    assign n_o     = r_n;
    assign ovf_o   = r_ovf;
    assign upd_o   = r_upd;

endmodule

// File: tb/tb_sum_accumulator.sv
// Directed bench for sum_accumulator: default instance plus a narrow-sum instance
// (SUM_W=10) so the overflow path is reachable before the count saturates.
module tb_sum_accumulator;

    localparam int unsigned DATA_W  = 8;
    localparam int unsigned SUM_W   = 16;
    localparam int unsigned CNT_W   = 8;
    localparam int unsigned SSUM_W  = 10;

    logic              clk_i;
    logic              rst_ni;
    logic              clear_i;
    logic              valid_i;
    logic [DATA_W-1:0] data_i;
    logic              ready_o;
    logic [SUM_W-1:0]  sum_o;
    logic [CNT_W-1:0]  n_o;
    logic              ovf_o;
    logic              upd_o;
    logic [DATA_W-1:0] max_o;

    logic              s_clear;
    logic              s_valid;
    logic [DATA_W-1:0] s_data;
    logic              s_ready;
    logic [SSUM_W-1:0] s_sum;
    logic [CNT_W-1:0]  s_n;
    logic              s_ovf;
    logic              s_upd;
    logic [DATA_W-1:0] s_max;

    int n_tests;
    int n_fail;

    sum_accumulator #(.DATA_W(DATA_W), .SUM_W(SUM_W), .CNT_W(CNT_W)) u_dut (
        .clk_i(clk_i), .rst_ni(rst_ni), .clear_i(clear_i), .valid_i(valid_i),
        .data_i(data_i), .ready_o(ready_o), .sum_o(sum_o), .n_o(n_o),
        .ovf_o(ovf_o), .upd_o(upd_o), .max_o(max_o)
    );

    sum_accumulator #(.DATA_W(DATA_W), .SUM_W(SSUM_W), .CNT_W(CNT_W)) u_small (
        .clk_i(clk_i), .rst_ni(rst_ni), .clear_i(s_clear), .valid_i(s_valid),
        .data_i(s_data), .ready_o(s_ready), .sum_o(s_sum), .n_o(s_n),
        .ovf_o(s_ovf), .upd_o(s_upd), .max_o(s_max)
    );

    initial clk_i = 1'b0;
    always #5 clk_i = ~clk_i;

    typedef struct {
        logic [7:0]  data;
        logic [15:0] sum;
        logic [7:0]  n;
        logic [7:0]  mx;
    } vec_t;

    vec_t vecs[6];

    function automatic logic [31:0] exp_max(input logic [31:0] m);
`ifdef SUM_ACCUMULATOR_MAX_EN
        return m;
`else
        return 32'd0 & m;
`endif
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk_i);
        #1;
    endtask

    task automatic do_clear();
        clear_i = 1'b1;
        tick();
        clear_i = 1'b0;
        check("clr_sum", 32'(sum_o), 32'd0);
        check("clr_n", 32'(n_o), 32'd0);
        check("clr_ovf", 32'(ovf_o), 32'd0);
        check("clr_upd", 32'(upd_o), 32'd1);
        check("clr_ready_low", 32'(ready_o), 32'd0);
        check("clr_max", 32'(max_o), 32'd0);
        tick();
        check("clr_ready_high", 32'(ready_o), 32'd1);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish, got timeout, expected $finish");
        $fatal(1);
    end

    initial begin
        n_tests = 0;
        n_fail  = 0;
        vecs[0] = '{8'd5,   16'd5,   8'd1, 8'd5};
        vecs[1] = '{8'd90,  16'd95,  8'd2, 8'd90};
        vecs[2] = '{8'd12,  16'd107, 8'd3, 8'd90};
        vecs[3] = '{8'd0,   16'd107, 8'd4, 8'd90};
        vecs[4] = '{8'd255, 16'd362, 8'd5, 8'd255};
        vecs[5] = '{8'd1,   16'd363, 8'd6, 8'd255};

        rst_ni = 1'b1; clear_i = 1'b0; valid_i = 1'b0; data_i = '0;
        s_clear = 1'b0; s_valid = 1'b0; s_data = '0;

        // Reset values, asserted between edges
        #2 rst_ni = 1'b0;
        #1;
        check("rst_ready", 32'(ready_o), 32'd0);
        check("rst_sum", 32'(sum_o), 32'd0);
        check("rst_n", 32'(n_o), 32'd0);
        check("rst_ovf", 32'(ovf_o), 32'd0);
        check("rst_upd", 32'(upd_o), 32'd0);
        check("rst_max", 32'(max_o), 32'd0);
        tick();
        rst_ni = 1'b1;
        check("idle_ready", 32'(ready_o), 32'd0);
        tick();
        check("acc_ready", 32'(ready_o), 32'd1);
        check("small_acc_ready", 32'(s_ready), 32'd1);

        // Back-to-back 3, 7, 10
        valid_i = 1'b1; data_i = 8'd3;
        tick();
        check("t1_sum0", 32'(sum_o), 32'd0);
        check("t1_upd0", 32'(upd_o), 32'd0);
        data_i = 8'd7;
        tick();
        check("t1_sum3", 32'(sum_o), 32'd3);
        check("t1_n1", 32'(n_o), 32'd1);
        check("t1_upd1", 32'(upd_o), 32'd1);
        data_i = 8'd10;
        tick();
        check("t1_sum10", 32'(sum_o), 32'd10);
        check("t1_upd2", 32'(upd_o), 32'd1);
        valid_i = 1'b0;
        tick();
        check("t1_sum20", 32'(sum_o), 32'd20);
        check("t1_n3", 32'(n_o), 32'd3);
        check("t1_upd3", 32'(upd_o), 32'd1);
        tick();
        check("t1_upd_end", 32'(upd_o), 32'd0);
        check("t1_sum_hold", 32'(sum_o), 32'd20);
        check("t1_max", 32'(max_o), exp_max(32'd10));

        // Table of isolated accepts from a cleared state
        do_clear();
        for (int i = 0; i < 6; i++) begin
            valid_i = 1'b1; data_i = vecs[i].data;
            tick();
            valid_i = 1'b0;
            tick();
            check($sformatf("vec%0d_sum", i), 32'(sum_o), 32'(vecs[i].sum));
            check($sformatf("vec%0d_n", i), 32'(n_o), 32'(vecs[i].n));
            check($sformatf("vec%0d_max", i), 32'(max_o), exp_max(32'(vecs[i].mx)));
        end

        // Count saturation: continuous 255s stop at n=255, sum=255*255
        do_clear();
        valid_i = 1'b1; data_i = 8'd255;
        repeat (300) tick();
        valid_i = 1'b0;
        tick();
        check("cnt_n", 32'(n_o), 32'd255);
        check("cnt_sum", 32'(sum_o), 32'd65025);
        check("cnt_ovf", 32'(ovf_o), 32'd0);
        check("cnt_ready", 32'(ready_o), 32'd0);
        check("cnt_upd", 32'(upd_o), 32'd0);
        check("cnt_max", 32'(max_o), exp_max(32'd255));
        valid_i = 1'b1; data_i = 8'd1;
        repeat (4) tick();
        valid_i = 1'b0;
        tick();
        check("full_ignore_sum", 32'(sum_o), 32'd65025);
        check("full_ignore_n", 32'(n_o), 32'd255);
        check("full_ready", 32'(ready_o), 32'd0);

        // Clear with a sample in flight discards it
        do_clear();
        valid_i = 1'b1; data_i = 8'd200;
        tick();
        valid_i = 1'b0; clear_i = 1'b1;
        tick();
        clear_i = 1'b0;
        check("fl_sum", 32'(sum_o), 32'd0);
        check("fl_n", 32'(n_o), 32'd0);
        check("fl_ready_low", 32'(ready_o), 32'd0);
        check("fl_upd", 32'(upd_o), 32'd1);
        tick();
        check("fl_ready_high", 32'(ready_o), 32'd1);
        tick();
        tick();
        check("fl_sum_after", 32'(sum_o), 32'd0);
        check("fl_n_after", 32'(n_o), 32'd0);
        check("fl_upd_after", 32'(upd_o), 32'd0);
        check("fl_max_after", 32'(max_o), 32'd0);

        // Overflow on the 10-bit instance: 5x200 + 100 saturates, 50 in flight still counted
        s_valid = 1'b1; s_data = 8'd200;
        repeat (5) tick();
        check("ov_sum800", 32'(s_sum), 32'd800);
        check("ov_n4", 32'(s_n), 32'd4);
        s_data = 8'd100;
        tick();
        check("ov_sum1000", 32'(s_sum), 32'd1000);
        check("ov_ready_pre", 32'(s_ready), 32'd1);
        s_data = 8'd50;
        tick();
        check("ov_sum_sat", 32'(s_sum), 32'd1023);
        check("ov_flag", 32'(s_ovf), 32'd1);
        check("ov_n6", 32'(s_n), 32'd6);
        check("ov_ready_drop", 32'(s_ready), 32'd0);
        tick();
        check("ov_inflight_n7", 32'(s_n), 32'd7);
        check("ov_inflight_sum", 32'(s_sum), 32'd1023);
        repeat (3) tick();
        s_valid = 1'b0;
        check("ov_hold_n", 32'(s_n), 32'd7);
        check("ov_sticky", 32'(s_ovf), 32'd1);
        check("ov_max", 32'(s_max), exp_max(32'd200));
        s_clear = 1'b1;
        tick();
        s_clear = 1'b0;
        check("ov_clr_flag", 32'(s_ovf), 32'd0);
        check("ov_clr_sum", 32'(s_sum), 32'd0);
        tick();
        check("ov_clr_ready", 32'(s_ready), 32'd1);

        // Asynchronous reset mid-stream, then restart
        valid_i = 1'b1; data_i = 8'd9;
        repeat (3) tick();
        check("mid_sum_pre", 32'(sum_o), 32'd18);
        #2 rst_ni = 1'b0;
        #1;
        check("arst_sum", 32'(sum_o), 32'd0);
        check("arst_n", 32'(n_o), 32'd0);
        check("arst_ready", 32'(ready_o), 32'd0);
        check("arst_upd", 32'(upd_o), 32'd0);
        check("arst_max", 32'(max_o), 32'd0);
        check("arst_small_sum", 32'(s_sum), 32'd0);
        valid_i = 1'b0;
        tick();
        tick();
        rst_ni = 1'b1;
        check("arst_idle_ready", 32'(ready_o), 32'd0);
        tick();
        check("arst_acc_ready", 32'(ready_o), 32'd1);
        valid_i = 1'b1; data_i = 8'd3;
        tick();
        data_i = 8'd7;
        tick();
        valid_i = 1'b0;
        tick();
        check("restart_sum", 32'(sum_o), 32'd10);
        check("restart_n", 32'(n_o), 32'd2);
        check("restart_max", 32'(max_o), exp_max(32'd7));

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
